// File: rtl/aes_stream_pkg.sv
// Shared AES stream types, widths and helpers.
// Used by the AES-192 decrypt feeder (aes_blk_packer).
package aes_stream_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_BYTE_W = 8;

    typedef logic [AES_BLK_W-1:0] aes_blk_t;

    typedef enum logic {
        ACC_FILL,
        ACC_FULL
    } acc_state_e;

    function automatic int beats(input int in_w);
        return AES_BLK_W / in_w;
    endfunction

endpackage

// File: rtl/aes_pack_out_reg.sv
// Output register stage of the block packer.
// Ports: clk, rst_n, load/load_data/load_last (from ACC),
//   ready (m_axis_tready), valid/data/last (m_axis), pop, can_load.
module aes_pack_out_reg
    import aes_stream_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     load,
    input  aes_blk_t load_data,
    input  logic     load_last,
    input  logic     ready,
    output logic     valid,
    output aes_blk_t data,
    output logic     last,
    output logic     pop,
    output logic     can_load
);

    assign pop      = valid & ready;
    // Register is free when empty or being drained this cycle.
    assign can_load = ~valid | ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_blk_packer.sv
// Packs an IN_W-bit AXI-Stream of ciphertext into 128-bit blocks.
// Ports: ap_clk, ap_rst_n, s_axis_* (in), m_axis_* (out), blk_cnt,
//   partial_err, err_clr. Macro AES_PACK_ZPAD_EN: zero-pad partials.
module aes_blk_packer
    import aes_stream_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic [IN_W-1:0]  s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    output logic [127:0]     m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             partial_err,
    input  logic             err_clr
);

    localparam int BEATS = beats(IN_W);
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    if ((AES_BLK_W % IN_W) != 0) begin : g_bad_w
        $fatal(1, "IN_W must divide 128");
    end
    if ((IN_W % AES_BYTE_W) != 0) begin : g_bad_b
        $fatal(1, "IN_W must be whole bytes");
    end

    acc_state_e       state_q, state_d;
    aes_blk_t         acc_q, acc_d;
    aes_blk_t         merged;
    logic             acc_last_q, acc_last_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    logic     in_fire, at_end, completing, partial, emit;
    logic     load, load_last, pop, can_load;
    aes_blk_t load_data;

    assign s_axis_tready = rdy_q & (state_q == ACC_FILL);
    assign in_fire       = s_axis_tvalid & s_axis_tready;
    assign at_end        = (idx_q == LAST_IDX);
    assign completing    = in_fire & (at_end | s_axis_tlast);
    assign partial       = in_fire & s_axis_tlast & ~at_end;

`ifdef AES_PACK_ZPAD_EN
    assign emit = completing;
`else
    // Partial blocks are discarded instead of emitted.
    assign emit = completing & ~partial;
`endif

    // Current word dropped into its slot; first beat is the MSW.
    always_comb begin
        merged = acc_q;
        merged[AES_BLK_W-1-int'(idx_q)*IN_W -: IN_W] = s_axis_tdata;
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        acc_last_d = acc_last_q;
        idx_d      = idx_q;
        load       = 1'b0;
        load_data  = acc_q;
        load_last  = acc_last_q;
        unique case (state_q)
            ACC_FILL: begin
                if (completing) begin
                    idx_d = '0;
                    acc_d = '0;
                    if (emit && can_load) begin
                        load      = 1'b1;
                        load_data = merged;
                        load_last = s_axis_tlast;
                    end else if (emit) begin
                        acc_d      = merged;
                        acc_last_d = s_axis_tlast;
                        state_d    = ACC_FULL;
                    end
                end else if (in_fire) begin
                    idx_d = idx_q + 1'b1;
                    acc_d = merged;
                end
            end
            ACC_FULL: begin
                if (can_load) begin
                    load       = 1'b1;
                    acc_d      = '0;
                    acc_last_d = 1'b0;
                    state_d    = ACC_FILL;
                end
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q    <= ACC_FILL;
            acc_q      <= '0;
            acc_last_q <= 1'b0;
            idx_q      <= '0;
            rdy_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_last_q <= acc_last_d;
            idx_q      <= idx_d;
            rdy_q      <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (pop) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (partial) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign blk_cnt     = cnt_q;
    assign partial_err = err_q;

    aes_pack_out_reg u_out (
        .clk       (ap_clk),
        .rst_n     (ap_rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .ready     (m_axis_tready),
        .valid     (m_axis_tvalid),
        .data      (m_axis_tdata),
        .last      (m_axis_tlast),
        .pop       (pop),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_aes_blk_packer.sv
// Directed self-checking bench for aes_blk_packer.
// Expectations adapt to AES_PACK_ZPAD_EN.
module tb_aes_blk_packer;

    localparam int IN_W  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [IN_W-1:0]  s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             s_tlast = 1'b0;
    logic [127:0]     m_tdata;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic             m_tlast;
    logic [CNT_W-1:0] blk_cnt;
    logic             perr;
    logic             err_clr = 1'b0;

    int vecs = 0;
    int errs = 0;
    logic [CNT_W-1:0] exp_cnt = '0;

    always #5 clk = ~clk;

    aes_blk_packer #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .ap_clk        (clk),
        .ap_rst_n      (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .blk_cnt       (blk_cnt),
        .partial_err   (perr),
        .err_clr       (err_clr)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        bit done = 1'b0;
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = s_tready;
            step();
        end
        if (!done) chk("send_timeout", 0, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] b, input logic l);
        for (int k = 0; k < 4; k++) begin
            send_beat(b[127-k*32 -: 32], l && (k == 3));
        end
    endtask

    task automatic recv(input string tag, input logic [127:0] exp,
                        input logic exp_last);
        bit got = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (m_tvalid) got = 1'b1;
            else step();
        end
        chk({tag, "_valid"}, got, 1);
        chk({tag, "_data"}, m_tdata, exp);
        chk({tag, "_last"}, m_tlast, exp_last);
        step();
        m_tready = 1'b0;
        exp_cnt++;
        chk({tag, "_cnt"}, blk_cnt, exp_cnt);
    endtask

    initial begin
        #2000000;
        $error("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] b;
        repeat (3) step();
        chk("rst_sready", s_tready, 0);
        chk("rst_mvalid", m_tvalid, 0);
        chk("rst_mdata", m_tdata, 0);
        chk("rst_mlast", m_tlast, 0);
        chk("rst_cnt", blk_cnt, 0);
        chk("rst_perr", perr, 0);
        rst_n = 1'b1;
        step();
        chk("rel_sready", s_tready, 1);

        // 1: single block, sink always ready
        m_tready = 1'b1;
        send_beat(32'h00112233, 1'b0);
        send_beat(32'h44556677, 1'b0);
        send_beat(32'h8899AABB, 1'b0);
        chk("t1_novalid", m_tvalid, 0);
        send_beat(32'hCCDDEEFF, 1'b1);
        chk("t1_lat", m_tvalid, 1);
        recv("t1", 128'h00112233445566778899AABBCCDDEEFF, 1'b1);

        // 2: backpressure with three blocks
        m_tready = 1'b0;
        send_blk(128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 1'b1);
        send_blk(128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, 1'b1);
        chk("t2_stall", s_tready, 0);
        repeat (10) step();
        chk("t2_hold_rdy", s_tready, 0);
        chk("t2_hold_v", m_tvalid, 1);
        chk("t2_hold_d", m_tdata, 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF);
        recv("t2a", 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF, 1'b1);
        chk("t2_resume", s_tready, 1);
        send_blk(128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF, 1'b1);
        recv("t2b", 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF, 1'b1);
        recv("t2c", 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF, 1'b1);

        // 3/4: partial packet
        send_beat(32'hDEADBEEF, 1'b0);
        send_beat(32'h01020304, 1'b1);
        chk("t3_perr", perr, 1);
`ifdef AES_PACK_ZPAD_EN
        recv("t3", 128'hDEADBEEF010203040000000000000000, 1'b1);
`else
        repeat (3) step();
        chk("t4_noout", m_tvalid, 0);
        chk("t4_cnt", blk_cnt, exp_cnt);
`endif
        send_blk(128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1);
        recv("t4", 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b1);
        chk("t4_sticky", perr, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("t4_clr", perr, 0);

        // set beats clear in the same cycle; tlast on beat 0
        err_clr = 1'b1;
        send_beat(32'hA5A5A5A5, 1'b1);
        chk("t4_prio", perr, 1);
        err_clr = 1'b0;
`ifdef AES_PACK_ZPAD_EN
        recv("t4z", 128'hA5A5A5A5000000000000000000000000, 1'b1);
`endif

        // 5: counter wrap with CNT_W=4
        for (int n = 0; n < 20 && exp_cnt != 4'd15; n++) begin
            b = {4{32'(n) ^ 32'h5A5A0000}};
            send_blk(b, 1'b1);
            recv("t5", b, 1'b1);
        end
        chk("t5_15", blk_cnt, 15);
        b = 128'h11112222333344445555666677778888;
        send_blk(b, 1'b0);
        recv("t5w", b, 1'b0);
        chk("t5_0", blk_cnt, 0);
        send_blk(~b, 1'b1);
        recv("t5x", ~b, 1'b1);
        chk("t5_1", blk_cnt, 1);

        // 6: async reset mid-block
        send_beat(32'h11111111, 1'b0);
        send_beat(32'h22222222, 1'b0);
        chk("t6_pre_perr", perr, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_sready", s_tready, 0);
        chk("t6_mvalid", m_tvalid, 0);
        chk("t6_cnt", blk_cnt, 0);
        chk("t6_perr", perr, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_mdata", m_tdata, 0);
        chk("t6_mlast", m_tlast, 0);
        rst_n = 1'b1;
        exp_cnt = '0;
        step();
        chk("t6_rel", s_tready, 1);
        send_blk(128'h76543210_FEDCBA98_01234567_89ABCDEF, 1'b1);
        recv("t6", 128'h76543210_FEDCBA98_01234567_89ABCDEF, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
